btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// Branch-target-buffer update controller: buffers resolved branches, flags
// mispredictions and sequences 2-bit counter updates into the branch table.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc4,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_hit,
  input  logic        res_pred,
  output logic        wrt,
  output logic        wrp,
  output logic [31:0] PC4d,
  output logic [31:0] BdestIN,
  output logic        Pin,
  output logic        mispredict,
  output logic [31:0] redirect,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e        state_q;

  logic [31:0]   fifoPc4_q    [FIFO_DEPTH];
  logic [31:0]   fifoTarget_q [FIFO_DEPTH];
  logic          fifoTaken_q  [FIFO_DEPTH];
  logic          fifoHit_q    [FIFO_DEPTH];
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] wrPtr_q;
  logic [AW:0]   count_q;

  logic [31:0]   workPc4_q;
  logic [31:0]   workTarget_q;
  logic          workTaken_q;
  logic          workHit_q;

  logic [1:0]    cnt_q [16];
  logic [1:0]    newCnt_q;
  logic          cntWrite_q;

  logic          wrt_q;
  logic          wrp_q;
  logic          pin_q;
  logic [31:0]   pc4d_q;
  logic [31:0]   bdest_q;
  logic          mispredict_q;
  logic [31:0]   redirect_q;

  logic          fifoEmpty;
  logic          fifoFull;
  logic          push;
  logic          pop;
  logic [3:0]    workIdx;
  logic [1:0]    oldCnt;
  logic [1:0]    calcCnt_d;
  logic          calcWrite_d;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_C);
  assign res_ready = !fifoFull;
  assign push      = res_valid && !fifoFull;
  assign pop       = !fifoEmpty && ((state_q == IDLE) || (state_q == WRITE));
  assign busy      = (state_q != IDLE) || !fifoEmpty;

  assign wrt        = wrt_q;
  assign wrp        = wrp_q;
  assign Pin        = pin_q;
  assign PC4d       = pc4d_q;
  assign BdestIN    = bdest_q;
  assign mispredict = mispredict_q;
  assign redirect   = redirect_q;

  assign workIdx = workPc4_q[5:2];
  assign oldCnt  = cnt_q[workIdx];

  // Counter policy: hits train up/down with saturation, a taken miss allocates
  // as weakly-taken, and a not-taken miss leaves the table untouched.
  always_comb begin
    calcCnt_d   = oldCnt;
    calcWrite_d = workHit_q || workTaken_q;
    if (workHit_q) begin
      if (workTaken_q) begin
        calcCnt_d = (oldCnt == 2'd3) ? 2'd3 : oldCnt + 2'd1;
      end else begin
        calcCnt_d = (oldCnt == 2'd0) ? 2'd0 : oldCnt - 2'd1;
      end
    end else if (workTaken_q) begin
      calcCnt_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoPc4_q[wrPtr_q]    <= res_pc4;
      fifoTarget_q[wrPtr_q] <= res_target;
      fifoTaken_q[wrPtr_q]  <= res_taken;
      fifoHit_q[wrPtr_q]    <= res_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Misprediction is judged at acceptance so the flush never waits on the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= push && ((res_hit && res_pred) != res_taken);
      if (push) begin
        redirect_q <= res_taken ? res_target : res_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      workPc4_q    <= '0;
      workTarget_q <= '0;
      workTaken_q  <= 1'b0;
      workHit_q    <= 1'b0;
      newCnt_q     <= '0;
      cntWrite_q   <= 1'b0;
      wrt_q        <= 1'b0;
      wrp_q        <= 1'b0;
      pin_q        <= 1'b0;
      pc4d_q       <= '0;
      bdest_q      <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      wrt_q <= 1'b0;
      wrp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            workPc4_q    <= fifoPc4_q[rdPtr_q];
            workTarget_q <= fifoTarget_q[rdPtr_q];
            workTaken_q  <= fifoTaken_q[rdPtr_q];
            workHit_q    <= fifoHit_q[rdPtr_q];
            state_q      <= CALC;
          end
        end
        CALC: begin
          newCnt_q   <= calcCnt_d;
          cntWrite_q <= calcWrite_d;
          wrp_q      <= calcWrite_d;
          wrt_q      <= workTaken_q;
          if (calcWrite_d) begin
            pin_q   <= calcCnt_d[1];
            pc4d_q  <= workPc4_q;
            bdest_q <= workTarget_q;
          end
          state_q <= WRITE;
        end
        WRITE: begin
          // Committing here keeps the next CALC reading the fresh value.
          if (cntWrite_q) begin
            cnt_q[workIdx] <= newCnt_q;
          end
          if (pop) begin
            workPc4_q    <= fifoPc4_q[rdPtr_q];
            workTarget_q <= fifoTarget_q[rdPtr_q];
            workTaken_q  <= fifoTaken_q[rdPtr_q];
            workHit_q    <= fifoHit_q[rdPtr_q];
            state_q      <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes expectations from a
// behavioural counter model, an independent monitor pops and compares them.
module tb_btb_update_ctrl;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc4;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_hit;
  logic        res_pred;
  logic        wrt;
  logic        wrp;
  logic [31:0] PC4d;
  logic [31:0] BdestIN;
  logic        Pin;
  logic        mispredict;
  logic [31:0] redirect;
  logic        busy;

  btb_update_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc4(res_pc4), .res_taken(res_taken), .res_target(res_target),
    .res_hit(res_hit), .res_pred(res_pred),
    .wrt(wrt), .wrp(wrp), .PC4d(PC4d), .BdestIN(BdestIN), .Pin(Pin),
    .mispredict(mispredict), .redirect(redirect), .busy(busy)
  );

  typedef struct {
    int          due;
    logic        misp;
    logic [31:0] redir;
  } mispExp_t;

  typedef struct {
    int          acc;
    int          lat;
    logic        wrt;
    logic        wrp;
    logic        pin;
    logic [31:0] pc4;
    logic [31:0] target;
  } wrExp_t;

  mispExp_t mispQ[$];
  wrExp_t   writeQ[$];
  int       modelCnt [16];
  int       total;
  int       bad;
  int       cyc;
  int       stallCount;
  bit       monitorOn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelCnt[i] = 1;
    mispQ.delete();
    writeQ.delete();
  endtask

  // Behavioural model: updates are applied in acceptance order, so the table
  // state can be advanced immediately when a resolution is accepted.
  task automatic modelAccept(input logic [31:0] pc4, input logic taken,
                             input logic [31:0] target, input logic hit,
                             input logic pred, input int lat);
    mispExp_t m;
    wrExp_t   w;
    int       idx;
    int       c;
    m.due   = cyc + 1;
    m.misp  = ((hit && pred) != taken);
    m.redir = taken ? target : pc4;
    mispQ.push_back(m);
    idx = int'(pc4[5:2]);
    c   = modelCnt[idx];
    if (hit || taken) begin
      if (!hit)       c = 2;
      else if (taken) c = (c < 3) ? c + 1 : 3;
      else            c = (c > 0) ? c - 1 : 0;
      modelCnt[idx] = c;
      w.acc    = cyc;
      w.lat    = lat;
      w.wrt    = taken;
      w.wrp    = 1'b1;
      w.pin    = (c >= 2);
      w.pc4    = pc4;
      w.target = target;
      writeQ.push_back(w);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc4, input logic taken,
                               input logic [31:0] target, input logic hit,
                               input logic pred, input int lat);
    bit accepted = 0;
    res_valid  = 1'b1;
    res_pc4    = pc4;
    res_taken  = taken;
    res_target = target;
    res_hit    = hit;
    res_pred   = pred;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (res_ready) begin
        accepted = 1;
        modelAccept(pc4, taken, target, hit, pred, lat);
      end else begin
        stallCount++;
      end
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycle();
    res_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    res_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    rst = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 0;
    res_valid = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && writeQ.size() == 0 && mispQ.size() == 0) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) checkOutput("drain timeout", 32'd0, 32'd1);
  endtask

  // A hit-taken followed by a hit-not-taken only yields Pin 1 then 0 when
  // the counter started at 01, and it returns the counter to 01.
  task automatic probeCounter(input logic [31:0] pc4);
    applyStimulus(pc4, 1'b1, pc4 + 32'h100, 1'b1, 1'b1, 0);
    applyStimulus(pc4, 1'b0, pc4 + 32'h100, 1'b1, 1'b1, 0);
  endtask

  // Monitor: compares every flush pulse and every table strobe against the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (mispQ.size() > 0 && mispQ[0].due == cyc) begin
        mispExp_t m;
        m = mispQ.pop_front();
        checkOutput("mispredict", {31'd0, mispredict}, {31'd0, m.misp});
        if (m.misp) checkOutput("redirect", redirect, m.redir);
      end else if (mispredict !== 1'b0) begin
        checkOutput("unexpected mispredict", {31'd0, mispredict}, 32'd0);
      end
      if (wrt !== 1'b0 || wrp !== 1'b0) begin
        if (writeQ.size() == 0) begin
          checkOutput("unexpected strobe", {30'd0, wrt, wrp}, 32'd0);
        end else begin
          wrExp_t w;
          w = writeQ.pop_front();
          checkOutput("wrt", {31'd0, wrt}, {31'd0, w.wrt});
          checkOutput("wrp", {31'd0, wrp}, {31'd0, w.wrp});
          checkOutput("Pin", {31'd0, Pin}, {31'd0, w.pin});
          checkOutput("PC4d", PC4d, w.pc4);
          checkOutput("BdestIN", BdestIN, w.target);
          if (w.lat != 0) checkOutput("strobe latency", cyc - w.acc, w.lat);
        end
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] pc;
    total = 0; bad = 0; cyc = 0; stallCount = 0; monitorOn = 0;
    rst = 1'b1; res_valid = 1'b0; res_pc4 = '0; res_taken = 1'b0;
    res_target = '0; res_hit = 1'b0; res_pred = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    monitorOn = 1;

    @(negedge clk);
    checkOutput("reset res_ready", {31'd0, res_ready}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset outputs", {29'd0, wrt, wrp, Pin}, 32'd0);
    checkOutput("reset PC4d", PC4d, 32'd0);
    checkOutput("reset BdestIN", BdestIN, 32'd0);
    checkOutput("reset redirect", redirect, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] allocate and saturation");
    applyStimulus(32'h0000_1044, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 3);
    waitDrain();
    for (int i = 0; i < 3; i++) applyStimulus(32'h0000_1044, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 0);
    applyStimulus(32'h0000_1044, 1'b0, 32'h0000_2000, 1'b1, 1'b1, 0);
    waitDrain();

    $display("[TB] miss not-taken leaves counter alone");
    applyStimulus(32'h0000_0014, 1'b0, 32'h0000_0900, 1'b0, 1'b1, 0);
    waitDrain();
    probeCounter(32'h0000_0014);
    waitDrain();

    $display("[TB] hit-taken predicted not-taken");
    applyStimulus(32'h0000_4008, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 3);
    waitDrain();

    $display("[TB] backpressure");
    stallCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'h0000_0100 + 32'(i * 4), i[0], 32'h0000_8000 + 32'(i * 16), i[1], 1'b1, 0);
    end
    checkOutput("backpressure stall seen", {31'd0, (stallCount > 0)}, 32'd1);
    waitDrain();

    $display("[TB] reset mid-operation");
    applyStimulus(32'h0000_0018, 1'b1, 32'h0000_0500, 1'b1, 1'b1, 3);
    applyStimulus(32'h0000_0058, 1'b1, 32'h0000_0600, 1'b0, 1'b0, 0);
    applyStimulus(32'h0000_0098, 1'b1, 32'h0000_0700, 1'b1, 1'b0, 0);
    applyStimulus(32'h0000_00D8, 1'b0, 32'h0000_0800, 1'b1, 1'b1, 0);
    doReset();
    @(negedge clk);
    checkOutput("post-reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post-reset res_ready", {31'd0, res_ready}, 32'd1);
    checkOutput("post-reset strobes", {30'd0, wrt, wrp}, 32'd0);
    @(posedge clk);
    #1;
    probeCounter(32'h0000_0018);
    probeCounter(32'h0000_1044);
    waitDrain();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 3) begin
        doReset();
      end else if (rnd < 25) begin
        idleCycle();
      end else begin
        pc  = $urandom();
        rnd = $urandom();
        pc  = {pc[31:6], 2'b00, rnd[1:0], 2'b00};
        applyStimulus(pc, rnd[2], {rnd[31:8], 8'h00}, rnd[3], rnd[4], 0);
      end
    end
    waitDrain();

    checkOutput("leftover writes", writeQ.size(), 32'd0);
    checkOutput("leftover mispredicts", mispQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
